// File: rtl/ice_cmd_pkg.sv
// ice_cmd_pkg: shared state encoding, host type-byte constants and byte width for the ICE command framer.
package ice_cmd_pkg;
    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] TYPE_MBUS_TX = 8'h62;
    localparam logic [BYTE_W-1:0] TYPE_VER_Q   = 8'h56;
    typedef enum logic [2:0] {IDLE, HDR_ID, HDR_LEN, PAYLOAD, PRESENT, DRAIN} state_t;
endpackage

// File: rtl/ice_cmd_framer_if.sv
// ice_cmd_framer_if: UART byte input plus header/payload handshake bundle between framer (master) and consumer (slave).
interface ice_cmd_framer_if;
    import ice_cmd_pkg::*;
    logic              rx_latch;
    logic [BYTE_W-1:0] rx_data;
    logic              frame_valid;
    logic              frame_ready;
    logic [BYTE_W-1:0] frame_type;
    logic [BYTE_W-1:0] frame_event_id;
    logic [BYTE_W-1:0] frame_len;
    logic [BYTE_W-1:0] pl_data;
    logic              pl_valid;
    logic              pl_ready;
    logic              pl_last;
    logic              rx_overrun;
    logic              frame_abort;
    logic              busy;
    modport master (
        input  rx_latch, rx_data, frame_ready, pl_ready,
        output frame_valid, frame_type, frame_event_id, frame_len,
               pl_data, pl_valid, pl_last, rx_overrun, frame_abort, busy
    );
    modport slave (
        output rx_latch, rx_data, frame_ready, pl_ready,
        input  frame_valid, frame_type, frame_event_id, frame_len,
               pl_data, pl_valid, pl_last, rx_overrun, frame_abort, busy
    );
endinterface

// File: rtl/ice_cmd_framer_buf.sv
// ice_cmd_framer_buf: simple dual-port payload RAM, one write port and one registered read port.
module ice_cmd_framer_buf
    import ice_cmd_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [BYTE_W-1:0] o_rdata
);
    logic [BYTE_W-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/ice_cmd_framer.sv
// ice_cmd_framer: store-and-forward rebuild of [type][id][len][payload] host frames from the UART byte stream.
// Optional inter-byte timeout abort is enabled by defining ICE_FRAME_TIMEOUT_EN.
module ice_cmd_framer
    import ice_cmd_pkg::*;
#(
    parameter int BUF_AW = 8
`ifdef ICE_FRAME_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 200000
`endif
) (
    input  logic              clk,
    input  logic              reset,
    ice_cmd_framer_if.master  bus
);
    state_t              r_state, w_next;
    logic                r_latch_d, r_cap;
    logic [BYTE_W-1:0]   r_byte, r_type, r_id, r_len;
    logic [BUF_AW-1:0]   r_wr_ptr, r_rd_ptr, w_len, w_raddr;
    logic [BYTE_W-1:0]   w_rdata;
    logic                w_hs_frame, w_hs_pl, w_last, w_re, w_tmo;

    assign w_len      = BUF_AW'(r_len);
    assign w_hs_frame = (r_state == PRESENT) && bus.frame_ready;
    assign w_hs_pl    = (r_state == DRAIN) && bus.pl_ready;
    assign w_last     = r_rd_ptr == w_len - BUF_AW'(1);
    // Read port only advances on a handshake so pl_data holds through stalls
    assign w_re       = (w_hs_frame && r_len != '0) || (w_hs_pl && !w_last);
    assign w_raddr    = w_hs_frame ? '0 : r_rd_ptr + BUF_AW'(1);

    ice_cmd_framer_buf #(.AW(BUF_AW)) u_buf (
        .clk     (clk),
        .i_we    (r_cap && r_state == PAYLOAD),
        .i_waddr (r_wr_ptr),
        .i_wdata (r_byte),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

`ifdef ICE_FRAME_TIMEOUT_EN
    logic [31:0] r_idle;
    logic        w_counting;
    assign w_counting = r_state == HDR_ID || r_state == HDR_LEN || r_state == PAYLOAD;
    assign w_tmo      = w_counting && !r_cap && r_idle == 32'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!reset || r_cap || !w_counting) r_idle <= '0;
        else r_idle <= r_idle + 32'd1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = r_cap ? HDR_ID : IDLE;
            HDR_ID:  w_next = r_cap ? HDR_LEN : HDR_ID;
            HDR_LEN: w_next = !r_cap ? HDR_LEN : (r_byte == '0) ? PRESENT : PAYLOAD;
            PAYLOAD: w_next = (r_cap && r_wr_ptr + BUF_AW'(1) == w_len) ? PRESENT : PAYLOAD;
            PRESENT: w_next = !bus.frame_ready ? PRESENT : (r_len == '0) ? IDLE : DRAIN;
            DRAIN:   w_next = (w_hs_pl && w_last) ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
        if (w_tmo) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_latch_d <= 1'b0;
            r_cap     <= 1'b0;
            r_byte    <= '0;
            r_type    <= '0;
            r_id      <= '0;
            r_len     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            r_state   <= w_next;
            r_latch_d <= bus.rx_latch;
            r_cap     <= bus.rx_latch && !r_latch_d;
            r_byte    <= bus.rx_data;
            if (r_cap && r_state == IDLE) r_type <= r_byte;
            if (r_cap && r_state == HDR_ID) r_id <= r_byte;
            if (r_cap && r_state == HDR_LEN) r_len <= r_byte;
            if (r_cap && r_state == HDR_LEN) r_wr_ptr <= '0;
            else if (r_cap && r_state == PAYLOAD) r_wr_ptr <= r_wr_ptr + BUF_AW'(1);
            if (w_hs_frame) r_rd_ptr <= '0;
            else if (w_hs_pl) r_rd_ptr <= r_rd_ptr + BUF_AW'(1);
        end
    end

    assign bus.frame_valid    = r_state == PRESENT;
    assign bus.frame_type     = r_type;
    assign bus.frame_event_id = r_id;
    assign bus.frame_len      = r_len;
    assign bus.pl_valid       = r_state == DRAIN;
    assign bus.pl_data        = (r_state == DRAIN) ? w_rdata : '0;
    assign bus.pl_last        = (r_state == DRAIN) && w_last;
    assign bus.rx_overrun     = r_cap && (r_state == PRESENT || r_state == DRAIN);
    assign bus.frame_abort    = w_tmo;
    assign bus.busy           = r_state != IDLE;
endmodule

// File: tb/tb_ice_cmd_framer.sv
// tb_ice_cmd_framer: random and directed frames against a queue-based expected-frame model of the framer.
module tb_ice_cmd_framer;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tot = 0, n_bad = 0, n_ovr = 0, n_abt = 0;

    ice_cmd_framer_if bus();

    ice_cmd_framer #(
        .BUF_AW(8)
`ifdef ICE_FRAME_TIMEOUT_EN
        , .TIMEOUT_CYCLES(1000)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_overrun) n_ovr++;
        if (bus.frame_abort) n_abt++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return {25'd0, bus.frame_valid, bus.frame_type, bus.frame_event_id, bus.frame_len,
                bus.pl_data, bus.pl_valid, bus.pl_last, bus.rx_overrun, bus.frame_abort, bus.busy};
    endfunction

    // Hold rx_latch high a random number of cycles: each rise must count as exactly one byte
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_latch = 1'b1;
        tick($urandom_range(1, 3));
        bus.rx_latch = 1'b0;
        tick($urandom_range(2, 3));
    endtask

    task automatic send_frame(input logic [7:0] t, input logic [7:0] id, input bq_t pl);
        send_byte(t);
        send_byte(id);
        send_byte(8'(pl.size()));
        foreach (pl[i]) send_byte(pl[i]);
    endtask

    // mode 0: pl_ready always 1; 1: pattern 1-0-0-1; 2: random
    task automatic take_frame(input logic [7:0] t, input logic [7:0] id, input bq_t pl, input int mode);
        int k = 0, idx = 0, cyc = 0;
        logic rdy;
        logic stalled = 1'b0;
        logic [8:0] held = '0;
        logic [3:0] pat = 4'b1001;
        while (!bus.frame_valid && k < 100) begin
            tick(1);
            k++;
        end
        chk("frame_valid", bus.frame_valid, 1);
        chk("frame_type", bus.frame_type, t);
        chk("frame_id", bus.frame_event_id, id);
        chk("frame_len", bus.frame_len, pl.size());
        bus.frame_ready = 1'b1;
        tick(1);
        bus.frame_ready = 1'b0;
        chk("fv_drop", bus.frame_valid, 0);
        chk("pl_valid_lat", bus.pl_valid, pl.size() != 0);
        if (pl.size() == 0) begin
            tick(2);
            chk("len0_nopl", {bus.pl_valid, bus.busy}, 0);
        end
        while (idx < pl.size() && cyc < 2000) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            bus.pl_ready = rdy;
            if (mode == 0) chk("pl_cont", bus.pl_valid, 1);
            if (stalled) chk("pl_hold", {bus.pl_valid, bus.pl_last, bus.pl_data}, {1'b1, held});
            stalled = 1'b0;
            if (bus.pl_valid && rdy) begin
                chk("pl_data", bus.pl_data, pl[idx]);
                chk("pl_last", bus.pl_last, idx == pl.size() - 1);
                idx++;
            end else if (bus.pl_valid) begin
                held = {bus.pl_last, bus.pl_data};
                stalled = 1'b1;
            end
            tick(1);
            cyc++;
        end
        bus.pl_ready = 1'b0;
        chk("pl_count", idx, pl.size());
        chk("idle_after", {bus.pl_valid, bus.busy}, 0);
    endtask

    initial begin
        bq_t f1, pl, empty;
        int k, ov0;
        f1 = '{8'hf0, 8'h12, 8'h34, 8'h50, 8'hde, 8'had, 8'hbe, 8'hef};
        empty = {};
        bus.rx_latch = 1'b0;
        bus.rx_data = '0;
        bus.frame_ready = 1'b0;
        bus.pl_ready = 1'b0;
        tick(3);
        chk("reset_outs", outs(), 0);
        reset = 1'b1;
        tick(2);

        send_frame(8'h62, 8'h0c, f1);
        take_frame(8'h62, 8'h0c, f1, 0);

        send_frame(8'h56, 8'h00, empty);
        take_frame(8'h56, 8'h00, empty, 0);

        send_frame(8'h62, 8'h0c, f1);
        take_frame(8'h62, 8'h0c, f1, 1);

        pl = {};
        for (int i = 0; i < 24; i++) pl.push_back(8'($urandom));
        send_frame(8'h62, 8'h14, pl);
        ov0 = n_ovr;
        fork
            take_frame(8'h62, 8'h14, pl, 1);
            begin
                k = 0;
                while (!bus.pl_valid && k < 100) begin
                    tick(1);
                    k++;
                end
                tick(3);
                send_byte(8'h99);
            end
        join
        chk("overrun_cnt", n_ovr - ov0, 1);
        send_frame(8'h62, 8'h0c, f1);
        take_frame(8'h62, 8'h0c, f1, 0);

`ifdef ICE_FRAME_TIMEOUT_EN
        begin
            int a0 = n_abt;
            send_byte(8'h62);
            send_byte(8'h0c);
            send_byte(8'h04);
            send_byte(8'haa);
            k = 0;
            while (n_abt == a0 && k < 1100) begin
                tick(1);
                k++;
            end
            chk("abort_cnt", n_abt - a0, 1);
            chk("abort_not_early", k >= 950, 1);
            tick(1);
            chk("abort_busy", bus.busy, 0);
            send_frame(8'h56, 8'h00, empty);
            take_frame(8'h56, 8'h00, empty, 0);
        end
`endif

        send_byte(8'h62);
        send_byte(8'h0c);
        send_byte(8'h08);
        send_byte(8'hf0);
        chk("mid_busy", bus.busy, 1);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        chk("midreset_outs", outs(), 0);
        tick(1);
        send_frame(8'h62, 8'h0c, f1);
        take_frame(8'h62, 8'h0c, f1, 0);

        for (int f = 0; f < 8; f++) begin
            logic [7:0] t, id;
            t = 8'($urandom);
            id = 8'($urandom);
            pl = {};
            for (int i = 0; i < $urandom_range(0, 40); i++) pl.push_back(8'($urandom));
            send_frame(t, id, pl);
            take_frame(t, id, pl, $urandom_range(0, 2));
        end

        chk("total_overruns", n_ovr, 1);
`ifndef ICE_FRAME_TIMEOUT_EN
        chk("no_abort", n_abt, 0);
`endif
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
